imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_loader_uart_rx.sv | 124 ++++++++++++
 rtl/imem_loader.sv | 199 +++++++++++++++++++
 tb/tb_imem_loader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the serial instruction-image loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    L_IDLE   = 3'd0,
    L_LEN_LO = 3'd1,
    L_LEN_HI = 3'd2,
    L_DATA   = 3'd3,
    L_CSUM   = 3'd4,
    L_DONE   = 3'd5,
    L_ERR    = 3'd6
  } load_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         MAX_WORDS = 1024;
  localparam int         IMEM_AW   = 10;

  // Running frame checksum: XOR of every data byte.
  function automatic logic [7:0] csum_next(input logic [7:0] csum, input logic [7:0] data);
    return csum ^ data;
  endfunction

endpackage

// File: rtl/imem_loader_uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, framing-error detect.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       in_RST,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       ferr
);

  localparam int            CW      = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3} rx_state_e;

  rx_state_e     state_q, state_d;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          fall_s;

  // A start candidate is a high-to-low transition of the synchronized line.
  assign fall_s = rx_prev_q & ~rx_sync_q;

  // Synchronizer, edge history and receiver state registers.
  always_ff @(posedge clk or negedge in_RST) begin
    if (!in_RST) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      shift_q   <= 8'd0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  // Bit-level FSM: validate start at half bit, then sample each bit at mid-bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (fall_s) begin
          state_d = RX_START;
          cnt_d   = '0;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = 3'd0;
          if (!rx_sync_q) begin
            state_d = RX_DATA;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            state_d = RX_DATA;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_sync_q) begin
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RX_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign ferr       = ferr_q;

endmodule

// File: rtl/imem_loader.sv
// Frame parser that streams a UART-delivered image into the instruction store.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115_200,
  parameter int TIMEOUT  = 1_000_000
) (
  input  logic               clk,
  input  logic               in_RST,
  input  logic               rx,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_err,
  output logic [10:0]        words_loaded
);

  localparam int            CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int            TW           = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LIM      = TW'(TIMEOUT);

  logic               bv_s, ferr_s, active_s;
  logic [7:0]         bd_s;
  logic [15:0]        len_word_s;
  load_state_e        state_q, state_d;
  logic [10:0]        words_q, words_d, len_q, len_d;
  logic [1:0]         idx_q, idx_d;
  logic [7:0]         csum_q, csum_d, len_lo_q, len_lo_d;
  logic [31:0]        word_q, word_d, wdata_q, wdata_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               we_q, we_d, hold_q, hold_d, done_q, done_d, err_q, err_d;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .in_RST     (in_RST),
    .rx         (rx),
    .byte_valid (bv_s),
    .byte_data  (bd_s),
    .ferr       (ferr_s)
  );

  assign active_s   = (state_q == L_LEN_LO) || (state_q == L_LEN_HI) ||
                      (state_q == L_DATA)   || (state_q == L_CSUM);
  assign len_word_s = {bd_s, len_lo_q};

  // Loader state and output registers.
  always_ff @(posedge clk or negedge in_RST) begin
    if (!in_RST) begin
      state_q  <= L_IDLE;
      words_q  <= 11'd0;
      len_q    <= 11'd0;
      idx_q    <= 2'd0;
      csum_q   <= 8'd0;
      len_lo_q <= 8'd0;
      word_q   <= 32'd0;
      wdata_q  <= 32'd0;
      addr_q   <= '0;
      tmo_q    <= '0;
      we_q     <= 1'b0;
      hold_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      words_q  <= words_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      csum_q   <= csum_d;
      len_lo_q <= len_lo_d;
      word_q   <= word_d;
      wdata_q  <= wdata_d;
      addr_q   <= addr_d;
      tmo_q    <= tmo_d;
      we_q     <= we_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Inter-byte timeout: runs only mid-frame and restarts on every received byte.
  always_comb begin
    if (bv_s || !active_s) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Frame FSM: framing error beats a byte, a byte beats the timeout.
  always_comb begin
    state_d  = state_q;
    words_d  = words_q;
    len_d    = len_q;
    idx_d    = idx_q;
    csum_d   = csum_q;
    len_lo_d = len_lo_q;
    word_d   = word_q;
    wdata_d  = wdata_q;
    addr_d   = addr_q;
    we_d     = 1'b0;
    hold_d   = hold_q;
    done_d   = done_q;
    err_d    = err_q;
    if (ferr_s && active_s) begin
      state_d = L_ERR;
      hold_d  = 1'b0;
      err_d   = 1'b1;
    end else if (bv_s) begin
      case (state_q)
        L_IDLE, L_DONE, L_ERR: begin
          if (bd_s == SYNC_BYTE) begin
            state_d = L_LEN_LO;
            words_d = 11'd0;
            idx_d   = 2'd0;
            csum_d  = 8'd0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            hold_d  = 1'b1;
          end else begin
            state_d = state_q;
          end
        end
        L_LEN_LO: begin
          len_lo_d = bd_s;
          state_d  = L_LEN_HI;
        end
        L_LEN_HI: begin
          if (len_word_s > 16'(MAX_WORDS)) begin
            state_d = L_ERR;
            hold_d  = 1'b0;
            err_d   = 1'b1;
          end else if (len_word_s == 16'd0) begin
            len_d   = 11'd0;
            state_d = L_CSUM;
          end else begin
            len_d   = len_word_s[10:0];
            state_d = L_DATA;
          end
        end
        L_DATA: begin
          csum_d = csum_next(csum_q, bd_s);
          idx_d  = idx_q + 2'd1;
          case (idx_q)
            2'd0:    word_d[7:0]   = bd_s;
            2'd1:    word_d[15:8]  = bd_s;
            2'd2:    word_d[23:16] = bd_s;
            default: word_d[31:24] = bd_s;
          endcase
          if (idx_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = words_q[IMEM_AW-1:0];
            wdata_d = {bd_s, word_q[23:0]};
            words_d = words_q + 11'd1;
            if ((words_q + 11'd1) == len_q) begin
              state_d = L_CSUM;
            end else begin
              state_d = L_DATA;
            end
          end else begin
            state_d = L_DATA;
          end
        end
        L_CSUM: begin
          hold_d = 1'b0;
          if (bd_s == csum_q) begin
            state_d = L_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = L_ERR;
            err_d   = 1'b1;
          end
        end
        default: begin
          state_d = L_IDLE;
        end
      endcase
    end else if (active_s && (tmo_q == TMO_LIM)) begin
      state_d = L_ERR;
      hold_d  = 1'b0;
      err_d   = 1'b1;
    end else begin
      state_d = state_q;
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_hold     = hold_q;
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader with a frame-level reference model.
module tb_imem_loader;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        in_RST;
  logic        rx;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold, load_done, load_err;
  logic [10:0] words_loaded;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0]  obs_addr[$];
  logic [31:0] obs_data[$];
  logic [9:0]  exp_addr[$];
  logic [31:0] exp_data[$];
  logic        exp_done, exp_err;
  logic [10:0] exp_words;
  logic [7:0]  frame[$];

  always #5 clk = ~clk;

  imem_loader #(.CLK_FREQ(16), .BAUD(1), .TIMEOUT(400)) dut (
    .clk          (clk),
    .in_RST       (in_RST),
    .rx           (rx),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  // Record every write strobe, sampled away from the active edge.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      obs_addr.push_back(imem_addr);
      obs_data.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serial byte at 16 clocks/bit; stop_bit=0 produces a framing error.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Expected outcome of a well-formed byte stream: skip to the first sync,
  // read the length, assemble little-endian words and compare the XOR.
  task automatic model_frame();
    int          s;
    int          p;
    int          n;
    logic [7:0]  cs;
    logic [31:0] w;
    exp_addr.delete();
    exp_data.delete();
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    exp_words = 11'd0;
    s = -1;
    for (int i = 0; i < frame.size(); i++) begin
      if (s < 0 && frame[i] == 8'hA5) s = i;
    end
    n = int'(frame[s+1]) + 256 * int'(frame[s+2]);
    if (n > 1024) begin
      exp_err = 1'b1;
    end else begin
      cs = 8'h00;
      p  = s + 3;
      for (int k = 0; k < n; k++) begin
        w = {frame[p+3], frame[p+2], frame[p+1], frame[p]};
        cs = cs ^ frame[p] ^ frame[p+1] ^ frame[p+2] ^ frame[p+3];
        exp_addr.push_back(10'(k));
        exp_data.push_back(w);
        p += 4;
      end
      exp_words = 11'(n);
      if (frame[p] == cs) exp_done = 1'b1;
      else                exp_err  = 1'b1;
    end
  endtask

  task automatic compare_result(input string tag);
    check({tag, "_nwr"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      check({tag, "_addr"}, 32'(obs_addr[i]), 32'(exp_addr[i]));
      check({tag, "_data"}, obs_data[i], exp_data[i]);
    end
    check({tag, "_done"}, 32'(load_done), 32'(exp_done));
    check({tag, "_err"},  32'(load_err),  32'(exp_err));
    check({tag, "_words"}, 32'(words_loaded), 32'(exp_words));
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
  endtask

  // Send the frame queue; optionally check hold mid-frame and glitch rx after a given byte.
  task automatic run_frame(input string tag, input bit chk_hold, input int glitch_after);
    obs_addr.delete();
    obs_data.delete();
    model_frame();
    for (int i = 0; i < frame.size(); i++) begin
      send_byte(frame[i], 1'b1);
      if (chk_hold && i < frame.size() - 1) check({tag, "_hold_mid"}, 32'(cpu_hold), 32'd1);
      if (i == glitch_after) begin
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
      end
    end
    repeat (4) @(negedge clk);
    compare_result(tag);
  endtask

  initial begin
    logic [7:0] cs;
    int         n;
    rx     = 1'b1;
    in_RST = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_we",    32'(imem_we),      32'd0);
    check("rst_addr",  32'(imem_addr),    32'd0);
    check("rst_wdata", imem_wdata,        32'd0);
    check("rst_hold",  32'(cpu_hold),     32'd0);
    check("rst_done",  32'(load_done),    32'd0);
    check("rst_err",   32'(load_err),     32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    in_RST = 1'b1;
    repeat (5) @(negedge clk);

    // Happy path.
    frame = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    run_frame("happy", 1'b1, -1);
    check("happy_w0", (obs_data.size() > 0) ? obs_data[0] : 32'hX, 32'h12345678);
    check("happy_w1", (obs_data.size() > 1) ? obs_data[1] : 32'hX, 32'hDEADBEEF);
    check("happy_done_const", 32'(load_done), 32'd1);

    // Bad checksum.
    frame = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2B};
    run_frame("badcs", 1'b1, -1);

    // Zero length and oversized length.
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame("zero", 1'b1, -1);
    frame = '{8'hA5, 8'h01, 8'h04};
    run_frame("over", 1'b1, -1);

    // Exactly 1024 words is accepted, then left to time out.
    obs_addr.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h04, 1'b1);
    repeat (4) @(negedge clk);
    check("max_err",  32'(load_err), 32'd0);
    check("max_hold", 32'(cpu_hold), 32'd1);
    repeat (500) @(negedge clk);
    check("max_tmo_err", 32'(load_err), 32'd1);

    // Framing error on a data byte.
    obs_addr.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    repeat (4) @(negedge clk);
    check("ferr_err",  32'(load_err), 32'd1);
    check("ferr_hold", 32'(cpu_hold), 32'd0);
    check("ferr_nwr",  32'(obs_addr.size()), 32'd0);

    // Stall inside DATA.
    obs_addr.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    repeat (300) @(negedge clk);
    check("tmo_early", 32'(load_err), 32'd0);
    repeat (200) @(negedge clk);
    check("tmo_err",   32'(load_err), 32'd1);
    check("tmo_hold",  32'(cpu_hold), 32'd0);
    check("tmo_nwr",   32'(obs_addr.size()), 32'd0);
    check("tmo_words", 32'(words_loaded), 32'd0);

    // Noise before sync and a short glitch mid-frame, restarting from ERR.
    frame = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h0D, 8'hF0, 8'hAD, 8'h0B, 8'h0D ^ 8'hF0 ^ 8'hAD ^ 8'h0B};
    run_frame("noise", 1'b0, 3);

    // Randomized frames.
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 4);
      frame = '{8'hA5, 8'(n), 8'h00};
      cs = 8'h00;
      for (int i = 0; i < 4 * n; i++) begin
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        frame.push_back(b);
        cs = cs ^ b;
      end
      if ($urandom_range(0, 1) == 1) cs = cs ^ 8'h01;
      frame.push_back(cs);
      run_frame("rand", 1'b1, -1);
    end

    // Reset during the third data byte.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    in_RST = 1'b0;
    rx     = 1'b1;
    repeat (3) @(negedge clk);
    check("mrst_we",    32'(imem_we),      32'd0);
    check("mrst_addr",  32'(imem_addr),    32'd0);
    check("mrst_wdata", imem_wdata,        32'd0);
    check("mrst_hold",  32'(cpu_hold),     32'd0);
    check("mrst_done",  32'(load_done),    32'd0);
    check("mrst_err",   32'(load_err),     32'd0);
    check("mrst_words", 32'(words_loaded), 32'd0);
    obs_addr.delete();
    in_RST = 1'b1;
    send_byte(8'hCC, 1'b1);
    repeat (300) @(negedge clk);
    check("mrst_nwr",   32'(obs_addr.size()), 32'd0);
    check("mrst_hold2", 32'(cpu_hold), 32'd0);
    check("mrst_err2",  32'(load_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
